mem_bus_initiator: RTL

- Bus initiator for the picorv32 native memory interface: the requesting end of the bus that the memory/MMIO responder serves.
- Accepts a byte-serial command stream (debug loader / host link), assembles single-word read or write transactions, and drives them onto the native bus.
- Returns the results as a byte-serial response stream.
- Sits beside the CPU, in front of a bus arbiter, so firmware can be loaded and MMIO registers (0x1000_0000, 0x2000_0000, 0x3000_0000) can be poked without the core.

---
 rtl/mem_bus_initiator_pkg.sv | 18 +
 rtl/mem_bus_initiator_if.sv | 26 ++
 rtl/mem_bus_initiator_byte_serializer.sv | 43 ++++
 rtl/mem_bus_initiator.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mem_bus_initiator_pkg.sv
// Shared types and protocol constants for the mem_bus_initiator byte-command bus master.
package mem_bus_initiator_pkg;

  typedef enum logic [2:0] {StOpc, StAddr, StData, StBus, StRsp} state_e;

  localparam logic [7:0] OPC_READ       = 8'h00;
  localparam logic [7:0] OPC_WRITE_MASK = 8'h80;
  localparam logic [7:0] ACK            = 8'hAA;
  localparam logic [7:0] ERR_OPC        = 8'hE0;
  localparam logic [7:0] ERR_ALIGN      = 8'hE1;
  localparam logic [7:0] ERR_TIMEOUT    = 8'hE2;

  // Write opcodes are 0x8S with a non-zero strobe nibble S.
  function automatic logic opc_is_write(input logic [7:0] opc);
    return ((opc & 8'hF0) == OPC_WRITE_MASK) && (opc[3:0] != 4'h0);
  endfunction

endpackage

// File: rtl/mem_bus_initiator_if.sv
// Command/response byte streams plus picorv32 native memory bus, seen from the initiator.
interface mem_bus_initiator_if;
  logic [7:0]  cmd_byte;
  logic        cmd_byte_en;
  logic        cmd_ready;
  logic [7:0]  rsp_byte;
  logic        rsp_byte_en;
  logic        rsp_ready;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    input  cmd_byte, cmd_byte_en, rsp_ready, mem_ready, mem_rdata,
    output cmd_ready, rsp_byte, rsp_byte_en, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output cmd_byte, cmd_byte_en, rsp_ready, mem_ready, mem_rdata,
    input  cmd_ready, rsp_byte, rsp_byte_en, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_bus_initiator_byte_serializer.sv
// Emits a loaded word as 1 or 4 bytes, LSB first, holding each byte until it is accepted.
module mem_bus_initiator_byte_serializer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        four_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        last_o
);

  logic [31:0] data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      data_d = word_i;
      cnt_d  = four_i ? 3'd4 : 3'd1;
    end else if ((cnt_q != 3'd0) && ready_i) begin
      data_d = {8'h00, data_q[31:8]};
      cnt_d  = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign byte_o  = data_q[7:0];
  assign valid_o = (cnt_q != 3'd0);
  assign last_o  = valid_o && ready_i && (cnt_q == 3'd1);

endmodule

// File: rtl/mem_bus_initiator.sv
// Byte-serial command to native-bus single-word read/write initiator.
// Optional bus timeout: define MEM_BUS_INITIATOR_TIMEOUT_EN.
module mem_bus_initiator
  import mem_bus_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 11
) (
  input logic             clk,
  input logic             resetn,
  mem_bus_initiator_if.master bus
);

  if (TIMEOUT_CYCLES >= (64'd1 << TO_W)) begin : g_cfg_check
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        write_q, write_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        ser_load;
  logic [31:0] ser_word;
  logic        ser_four;
  logic        ser_last;
  logic        cmd_fire;
  logic        bus_abort;

  assign bus.cmd_ready = (state_q == StOpc) || (state_q == StAddr) || (state_q == StData);
  assign cmd_fire      = bus.cmd_byte_en && bus.cmd_ready;

`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;

  always_comb begin
    to_d = '0;
    if (state_q == StBus && !bus.mem_ready) to_d = to_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) to_q <= '0;
    else         to_q <= to_d;
  end

  // Abort on the cycle the count would reach the limit; mem_ready that cycle still wins.
  assign bus_abort = (state_q == StBus) && !bus.mem_ready &&
                     (to_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign bus_abort = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    write_d  = write_q;
    wstrb_d  = wstrb_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ser_load = 1'b0;
    ser_word = '0;
    ser_four = 1'b0;
    unique case (state_q)
      StOpc: begin
        if (cmd_fire) begin
          idx_d = 2'd0;
          if (bus.cmd_byte == OPC_READ) begin
            write_d = 1'b0;
            wstrb_d = 4'h0;
            state_d = StAddr;
          end else if (opc_is_write(bus.cmd_byte)) begin
            write_d = 1'b1;
            wstrb_d = bus.cmd_byte[3:0];
            state_d = StAddr;
          end else begin
            ser_load = 1'b1;
            ser_word = {24'h0, ERR_OPC};
            state_d  = StRsp;
          end
        end
      end
      StAddr: begin
        if (cmd_fire) begin
          addr_d = {bus.cmd_byte, addr_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (write_q) begin
              state_d = StData;
            end else if (addr_d[1:0] != 2'b00) begin
              ser_load = 1'b1;
              ser_word = {24'h0, ERR_ALIGN};
              state_d  = StRsp;
            end else begin
              state_d = StBus;
            end
          end
        end
      end
      StData: begin
        if (cmd_fire) begin
          wdata_d = {bus.cmd_byte, wdata_q[31:8]};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (addr_q[1:0] != 2'b00) begin
              ser_load = 1'b1;
              ser_word = {24'h0, ERR_ALIGN};
              state_d  = StRsp;
            end else begin
              state_d = StBus;
            end
          end
        end
      end
      StBus: begin
        if (bus.mem_ready) begin
          ser_load = 1'b1;
          ser_word = write_q ? {24'h0, ACK} : bus.mem_rdata;
          ser_four = !write_q;
          state_d  = StRsp;
        end else if (bus_abort) begin
          ser_load = 1'b1;
          ser_word = {24'h0, ERR_TIMEOUT};
          state_d  = StRsp;
        end
      end
      StRsp: begin
        if (ser_last) state_d = StOpc;
      end
      default: state_d = StOpc;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StOpc;
      idx_q   <= '0;
      write_q <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  mem_bus_initiator_byte_serializer u_ser (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (ser_load),
    .word_i  (ser_word),
    .four_i  (ser_four),
    .byte_o  (bus.rsp_byte),
    .valid_o (bus.rsp_byte_en),
    .ready_i (bus.rsp_ready),
    .last_o  (ser_last)
  );

  assign bus.mem_valid = (state_q == StBus);
  assign bus.mem_instr = 1'b0;
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

endmodule
